// File: rtl/leaf_router.sv
// rtl/leaf_router.sv - leaf switch: four GPU NI ports plus one uplink, per-input FIFOs, round-robin per output
module leaf_router #(
    parameter int GROUP_ID   = 1,
    parameter int DATA_W     = 16,
    parameter int HEADER_W   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DATA_W-1:0]   leaf_in_data,
    input  logic [3:0]            leaf_in_valid,
    output logic [3:0]            leaf_in_ready,
    output logic [4*DATA_W-1:0]   leaf_out_data,
    output logic [3:0]            leaf_out_valid,
    input  logic [DATA_W-1:0]     up_in_data,
    input  logic                  up_in_valid,
    output logic                  up_in_ready,
    output logic [DATA_W-1:0]     up_out_data,
    output logic                  up_out_valid,
    input  logic                  up_out_ready,
    output logic [7:0]            drop_count
);
    localparam int NP    = 5;
    localparam int UP    = 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GRP_W = HEADER_W - 2;
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_RDY_MAX = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [GRP_W-1:0] GROUP       = GRP_W'(GROUP_ID);

    typedef logic [DATA_W-1:0] flit_t;

    flit_t             in_data [NP];
    logic [NP-1:0]     in_valid;
    flit_t             mem_q [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NP], wr_ptr_d [NP];
    logic [PTR_W-1:0]  rd_ptr_q [NP], rd_ptr_d [NP];
    logic [CNT_W-1:0]  cnt_q [NP], cnt_d [NP];
    logic [2:0]        rr_q [NP], rr_d [NP];
    flit_t             out_data_q [NP], out_data_d [NP];
    logic [NP-1:0]     out_valid_q, out_valid_d;
    logic [7:0]        drop_q, drop_d;

    logic [NP-1:0]     push, drop, pop, head_valid, out_en, gnt;
    flit_t             head [NP];
    logic [2:0]        dest [NP];
    logic [2:0]        gnt_src [NP];
    logic [2:0]        cand;
    logic [2:0]        ndrop;
    logic [8:0]        drop_sum;

    function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NP) s = s - NP;
        return 3'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_data[i]       = leaf_in_data[i*DATA_W +: DATA_W];
            leaf_in_ready[i] = (cnt_q[i] <= CNT_RDY_MAX);
        end
        in_data[UP] = up_in_data;
        in_valid    = {up_in_valid, leaf_in_valid};
        up_in_ready = (cnt_q[UP] <= CNT_RDY_MAX);
    end

    // Capture-side filtering; a full FIFO only happens if the sender ignores ready.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            drop[i] = in_valid[i] &&
                      ((in_data[i][DATA_W-1 -: HEADER_W] == '0) ||
                       ((i == UP) && (in_data[i][DATA_W-1 -: GRP_W] != GROUP)) ||
                       (cnt_q[i] == CNT_FULL));
            push[i] = in_valid[i] && !drop[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            head[i]       = mem_q[i][rd_ptr_q[i]];
            head_valid[i] = (cnt_q[i] != '0);
            dest[i]       = (head[i][DATA_W-1 -: GRP_W] == GROUP) ?
                            {1'b0, head[i][DATA_W-HEADER_W+1 -: 2]} : 3'(UP);
        end
    end

    // Per-output round robin; each input has a single head so grants never collide.
    always_comb begin
        out_en = {up_out_ready, 4'hF};
        pop    = '0;
        gnt    = '0;
        cand   = '0;
        for (int o = 0; o < NP; o++) begin
            gnt_src[o] = '0;
            for (int k = 1; k <= NP; k++) begin
                cand = rr_index(rr_q[o], k);
                if (!gnt[o] && out_en[o] && head_valid[cand] && (dest[cand] == 3'(o))) begin
                    gnt[o]     = 1'b1;
                    gnt_src[o] = cand;
                end
            end
            if (gnt[o]) pop[gnt_src[o]] = 1'b1;
            rr_d[o]        = gnt[o] ? gnt_src[o] : rr_q[o];
            out_valid_d[o] = gnt[o];
            out_data_d[o]  = gnt[o] ? head[gnt_src[o]] : out_data_q[o];
        end
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NP; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            ndrop       = ndrop + 3'(drop[i]);
        end
        drop_sum = 9'(drop_q) + 9'(ndrop);
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                cnt_q[i]      <= '0;
                rr_q[i]       <= '0;
                out_data_q[i] <= '0;
            end
            out_valid_q <= '0;
            drop_q      <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]   <= wr_ptr_d[i];
                rd_ptr_q[i]   <= rd_ptr_d[i];
                cnt_q[i]      <= cnt_d[i];
                rr_q[i]       <= rr_d[i];
                out_data_q[i] <= out_data_d[i];
            end
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i];
        end
    end

    always_comb begin
        for (int o = 0; o < 4; o++) leaf_out_data[o*DATA_W +: DATA_W] = out_data_q[o];
        leaf_out_valid = out_valid_q[3:0];
        up_out_data    = out_data_q[UP];
        up_out_valid   = out_valid_q[UP];
        drop_count     = drop_q;
    end
endmodule
